byte_serial_tx: RTL
===================

// Module: byte_serial_tx
// PURPOSE
//  Parallel-to-serial byte transmitter (UART-style framing). Accepts a byte over a
//  valid/ready handshake, shifts it out LSB-first with start/stop bits at a
//  programmable bit period. Transmit end of the team's serial link; a separate
//  deserializer block receives the sout line.
// PARAMETERS
//  DW         8   data bits per frame (1..16)
//  BAUD_DIV   4   clk cycles per serial bit (>=1; 1 = one bit per clk)
//  STOP_BITS  1   number of stop bits (1 or 2)
// PORTS
//  clk        in   1    system clock, all logic on posedge
//  rst        in   1    synchronous reset, active-high
//  din        in   DW   byte to transmit, sampled only on accept
//  din_valid  in   1    producer has a byte on din
//  din_ready  out  1    block can accept; accept = din_valid && din_ready
//  sout       out  1    serial line, idle high, registered
//  busy       out  1    frame in progress (START..STOP)
//  done       out  1    one-cycle pulse on last clk of final stop bit
// BEHAVIOUR
//  - One clock (clk); reset (rst) is synchronous and active-high.
//  - Reset values: sout=1, busy=0, done=0, state=IDLE, bit/tick counters=0.
//  - din_ready = (state==IDLE) && !rst; combinational from state.
//  - FSM: IDLE -accept-> START -1 bit period-> DATA -DW bit periods-> [PARITY] ->
//    STOP -STOP_BITS periods-> IDLE.
//  - On accept: din latched into shift reg; din changes afterwards ignored.
//  - sout is 0 for START, data bits LSB-first, 1 for each stop bit; sout updates
//    on the same edge the state or bit index advances.
//  - Bit period: tick counter counts 0..BAUD_DIV-1, restarts at 0 on accept;
//    bit advances when tick==BAUD_DIV-1. Bit index counter $clog2(DW) wide,
//    counts 0..DW-1, no wrap beyond DW-1.
//  - Frame length N = (1+DW+P+STOP_BITS)*BAUD_DIV clks, P=1 with parity else 0;
//    first START clk is the clk after accept; done asserted on clk N.
//  - busy=1 from clk 1 through clk N inclusive; done and busy both 1 on clk N.
//  - Back-to-back: state returns to IDLE on the edge ending clk N; din_ready=1 in
//    clk N+1; earliest next accept is clk N+1, next START at clk N+2. sout stays 1
//    between frames (minimum 1 idle clk).
//  - din_valid while busy: held off (din_ready=0), not dropped, no error.
//  - Reset mid-frame: frame abandoned; the next edge forces sout=1, IDLE,
//    busy=0; no done pulse for the aborted frame.
// CONFIGURATION
//  - Macro BYTE_TX_PARITY_EN: when defined, a PARITY state follows DATA for one bit
//    period, sout = ^data (even parity: total ones incl. parity bit even).
//    When undefined, no PARITY state exists and DATA goes directly to STOP.
// STRUCTURE
//  - Package byte_tx_pkg: typedef enum logic [2:0] {IDLE,START,DATA,PARITY,STOP}
//    tx_state_e; localparam IDLE_LVL=1'b1, START_LVL=1'b0.
//  - Sub-module baud_tick_gen (param BAUD_DIV; in clk, rst, restart; out tick):
//    tick pulses every BAUD_DIV clks, counter zeroed by restart.
//  - Top: FSM + shift reg + bit counter, one always_ff for state/datapath,
//    always_comb for next state/din_ready.
// TESTING (DW=8, BAUD_DIV=4, STOP_BITS=1)
//  - Reset: hold rst 3 clks -> sout=1, busy=0, done=0, din_ready=0 while rst=1,
//    then 1 in the clk after release.
//  - Single frame 0xA5, no parity -> sout 0,1,0,1,0,0,1,0,1,1, each 4 clks (40 clks);
//    done on clk 40.
//  - BYTE_TX_PARITY_EN, 0xA5 -> parity bit 0 inserted before stop, 44 clks; 0x07 ->
//    parity bit 1.
//  - Back-to-back 0x3C then 0xC3, din_valid held high -> second accept in clk 41,
//    sout=1 in clk 41, second START in clk 42, both decoded correctly.
//  - din toggled to 0xFF during frame 0x00 -> all data bits 0; din_valid while busy
//    -> din_ready=0, byte held and accepted after done.
//  - rst asserted at clk 17 of a frame -> sout=1 and busy=0 in the clk after that
//    edge, no done; next frame 0x81 is transmitted correctly.

Source files
------------

// File: rtl/byte_tx_pkg.sv
// Shared types and constants for the byte serial transmitter.
// Holds the FSM state encoding, the line levels and a counter width helper.
package byte_tx_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;

  // A counter must be at least one bit wide, even when it only ever holds 0.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period tick generator: tick is high on every BAUD_DIV-th clk.
// restart zeroes the count so a new frame begins on a clean bit boundary.
module baud_tick_gen #(
  parameter int BAUD_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);
  import byte_tx_pkg::*;

  localparam int            CW   = cnt_width(BAUD_DIV);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt_reg <= '0;
    end else if (cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/byte_serial_tx.sv
// UART-style byte transmitter: start bit, DW data bits LSB-first, stop bit(s).
// Define BYTE_TX_PARITY_EN to insert an even-parity bit between data and stop.
module byte_serial_tx #(
  parameter int DW        = 8,
  parameter int BAUD_DIV  = 4,
  parameter int STOP_BITS = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic          sout,
  output logic          busy,
  output logic          done
);
  import byte_tx_pkg::*;

  localparam int            BW        = cnt_width(DW);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DW - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  tx_state_e     state_reg, state_next;
  logic [DW-1:0] shift_reg;
  logic [BW-1:0] bit_reg;
  logic          sout_reg;
  logic          tick;
  logic          accept;
`ifdef BYTE_TX_PARITY_EN
  logic          parity_reg;
`endif

  baud_tick_gen #(.BAUD_DIV(BAUD_DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (accept),
    .tick    (tick)
  );

  // State register and datapath; sout changes on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sout_reg  <= IDLE_LVL;
      bit_reg   <= '0;
      shift_reg <= '0;
`ifdef BYTE_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            shift_reg <= din;
            bit_reg   <= '0;
            sout_reg  <= START_LVL;
`ifdef BYTE_TX_PARITY_EN
            parity_reg <= ^din;
`endif
          end
        end
        START: begin
          if (tick) begin
            sout_reg  <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_reg == BIT_LAST) begin
`ifdef BYTE_TX_PARITY_EN
              sout_reg <= parity_reg;
`else
              sout_reg <= IDLE_LVL;
`endif
              bit_reg  <= '0;
            end else begin
              sout_reg  <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
              bit_reg   <= bit_reg + 1'b1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            sout_reg <= IDLE_LVL;
          end
        end
        STOP: begin
          // bit_reg is reused to count stop-bit periods.
          if (tick) begin
            sout_reg <= IDLE_LVL;
            bit_reg  <= (bit_reg == STOP_LAST) ? '0 : bit_reg + 1'b1;
          end
        end
        default: begin
          sout_reg <= IDLE_LVL;
        end
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (accept) state_next = START;
      START:  if (tick) state_next = DATA;
      DATA: begin
        if (tick && (bit_reg == BIT_LAST)) begin
`ifdef BYTE_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
      PARITY: if (tick) state_next = STOP;
      STOP:   if (tick && (bit_reg == STOP_LAST)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    din_ready = (state_reg == IDLE) && !rst;
    accept    = din_valid && din_ready;
    busy      = (state_reg != IDLE);
    done      = (state_reg == STOP) && tick && (bit_reg == STOP_LAST) && !rst;
  end

  assign sout = sout_reg;

endmodule
